// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared state encodings for the bus arbiter control unit
package bus_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GRANT = 2'b01;
    localparam logic [1:0] ST_TURN  = 2'b10;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant bundle between requesters and the bus arbiter
interface bus_arbiter_if #(
    parameter int WIDTH = 3
);
    localparam int N = 2 ** WIDTH;

    logic [N-1:0]     req;
    logic [WIDTH-1:0] select;
    logic             EN;
    logic [N-1:0]     gnt;
    logic             timeout;

    // arbiter side
    modport master (
        input  req,
        output select,
        output EN,
        output gnt,
        output timeout
    );

    // requester / bus side
    modport slave (
        output req,
        input  select,
        input  EN,
        input  gnt,
        input  timeout
    );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational round-robin search starting after the last owner
module rr_pick #(
    parameter int WIDTH = 3
) (
    input  logic [2**WIDTH-1:0] req,
    input  logic [WIDTH-1:0]    last,
    output logic [WIDTH-1:0]    winner,
    output logic                valid
);
    localparam int N = 2 ** WIDTH;

    logic [WIDTH-1:0] idx;

    // Index arithmetic is WIDTH bits wide, so last+i wraps modulo N for free.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N; i++) begin
            idx = last + WIDTH'(i);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with mandatory turnaround cycle
// Optional grant timeout enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter_if.master bus
);
    localparam int N = 2 ** WIDTH;

    arb_state_t       state;
    logic [WIDTH-1:0] last;
    logic [WIDTH-1:0] select_q;
    logic             en_q;
    logic [N-1:0]     gnt_q;
    logic [WIDTH-1:0] winner;
    logic             valid;

    rr_pick #(.WIDTH(WIDTH)) u_pick (
        .req    (bus.req),
        .last   (last),
        .winner (winner),
        .valid  (valid)
    );

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] hold_cnt;
    logic          timeout_q;

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.select = select_q;
    assign bus.EN     = en_q;
    assign bus.gnt    = gnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            select_q <= '0;
            en_q     <= 1'b0;
            gnt_q    <= '0;
            last     <= WIDTH'(N - 1);
`ifdef BUS_ARBITER_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                ST_GRANT: begin
                    if (!bus.req[select_q]) begin
                        state <= ST_TURN;
                        en_q  <= 1'b0;
                        gnt_q <= '0;
                        last  <= select_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
                        hold_cnt <= '0;
                    end else if (hold_cnt == CW'(MAX_HOLD)) begin
                        // Owner still requesting: revoke and pulse timeout during TURN.
                        state     <= ST_TURN;
                        en_q      <= 1'b0;
                        gnt_q     <= '0;
                        last      <= select_q;
                        hold_cnt  <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
`endif
                    end
                end
                default: begin
                    if (valid) begin
                        state    <= ST_GRANT;
                        select_q <= winner;
                        en_q     <= 1'b1;
                        gnt_q    <= N'(1) << winner;
`ifdef BUS_ARBITER_TIMEOUT_EN
                        hold_cnt <= CW'(1);
`endif
                    end else begin
                        state <= ST_IDLE;
                        en_q  <= 1'b0;
                        gnt_q <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    bus_arbiter_if #(.WIDTH(3)) bus ();

    bus_arbiter #(.WIDTH(3), .MAX_HOLD(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = 8'h00;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.select, bus.EN, bus.gnt, bus.timeout} !== {3'd0, 1'b0, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs actual sel=%0d en=%0b gnt=%02h to=%0b required 0/0/00/0",
                     bus.select, bus.EN, bus.gnt, bus.timeout);
        end
        checks++;
        if (u_dut.state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset_state actual=%0d required=%0d", u_dut.state, ST_IDLE);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 8'h01;
        step();
        checks++;
        if ({bus.select, bus.EN, bus.gnt} !== {3'd0, 1'b1, 8'h01}) begin
            failures++;
            $display("FAIL single_grant actual sel=%0d en=%0b gnt=%02h required 0/1/01",
                     bus.select, bus.EN, bus.gnt);
        end
        bus.req = 8'h00;
        step();
        checks++;
        if ({bus.EN, bus.gnt, u_dut.state} !== {1'b0, 8'h00, ST_TURN}) begin
            failures++;
            $display("FAIL single_turn actual en=%0b gnt=%02h st=%0d required 0/00/%0d",
                     bus.EN, bus.gnt, u_dut.state, ST_TURN);
        end
        step();
        checks++;
        if ({bus.EN, bus.gnt, u_dut.state} !== {1'b0, 8'h00, ST_IDLE}) begin
            failures++;
            $display("FAIL single_idle actual en=%0b gnt=%02h st=%0d required 0/00/%0d",
                     bus.EN, bus.gnt, u_dut.state, ST_IDLE);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_gnt;
        logic [2:0] exp_sel;
        do_reset();
        bus.req = 8'hFF;
        step();
        for (int i = 0; i < 9; i++) begin
            exp_sel = 3'(i % 8);
            exp_gnt = 8'h01 << exp_sel;
            checks++;
            if ({bus.select, bus.EN, bus.gnt} !== {exp_sel, 1'b1, exp_gnt}) begin
                failures++;
                $display("FAIL rr_grant%0d actual sel=%0d en=%0b gnt=%02h required %0d/1/%02h",
                         i, bus.select, bus.EN, bus.gnt, exp_sel, exp_gnt);
            end
            step();
            checks++;
            if ({bus.select, bus.EN, bus.gnt} !== {exp_sel, 1'b1, exp_gnt}) begin
                failures++;
                $display("FAIL rr_hold%0d actual sel=%0d en=%0b gnt=%02h required %0d/1/%02h",
                         i, bus.select, bus.EN, bus.gnt, exp_sel, exp_gnt);
            end
            bus.req = 8'hFF & ~exp_gnt;
            step();
            checks++;
            if ({bus.select, bus.EN, bus.gnt} !== {exp_sel, 1'b0, 8'h00}) begin
                failures++;
                $display("FAIL rr_turn%0d actual sel=%0d en=%0b gnt=%02h required %0d/0/00",
                         i, bus.select, bus.EN, bus.gnt, exp_sel);
            end
            bus.req = 8'hFF;
            step();
        end
        bus.req = 8'h00;
        step();
        step();
    endtask

    task automatic test_no_preempt();
        do_reset();
        bus.req = 8'h08;
        step();
        bus.req = 8'h28;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.select, bus.EN, bus.gnt} !== {3'd3, 1'b1, 8'h08}) begin
                failures++;
                $display("FAIL nopreempt_hold%0d actual sel=%0d en=%0b gnt=%02h required 3/1/08",
                         i, bus.select, bus.EN, bus.gnt);
            end
        end
        bus.req = 8'h20;
        step();
        checks++;
        if ({bus.select, bus.EN, bus.gnt} !== {3'd3, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL nopreempt_turn actual sel=%0d en=%0b gnt=%02h required 3/0/00",
                     bus.select, bus.EN, bus.gnt);
        end
        step();
        checks++;
        if ({bus.select, bus.EN, bus.gnt} !== {3'd5, 1'b1, 8'h20}) begin
            failures++;
            $display("FAIL nopreempt_next actual sel=%0d en=%0b gnt=%02h required 5/1/20",
                     bus.select, bus.EN, bus.gnt);
        end
        bus.req = 8'h00;
        step();
        step();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        bus.req = 8'h40;
        step();
        checks++;
        if ({bus.select, bus.EN, bus.gnt} !== {3'd6, 1'b1, 8'h40}) begin
            failures++;
            $display("FAIL midrst_grant actual sel=%0d en=%0b gnt=%02h required 6/1/40",
                     bus.select, bus.EN, bus.gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.EN, bus.gnt} !== {1'b0, 8'h00}) begin
            failures++;
            $display("FAIL midrst_async actual en=%0b gnt=%02h required 0/00", bus.EN, bus.gnt);
        end
        bus.req = 8'h41;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({bus.select, bus.EN, bus.gnt} !== {3'd0, 1'b1, 8'h01}) begin
            failures++;
            $display("FAIL midrst_rearb actual sel=%0d en=%0b gnt=%02h required 0/1/01",
                     bus.select, bus.EN, bus.gnt);
        end
        bus.req = 8'h00;
        step();
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req = 8'h04;
        step();
        bus.req = 8'h00;
        step();
        checks++;
        if ({bus.EN, u_dut.state} !== {1'b0, ST_TURN}) begin
            failures++;
            $display("FAIL b2b_turn actual en=%0b st=%0d required 0/%0d", bus.EN, u_dut.state, ST_TURN);
        end
        bus.req = 8'h04;
        step();
        checks++;
        if ({bus.select, bus.EN, bus.gnt} !== {3'd2, 1'b1, 8'h04}) begin
            failures++;
            $display("FAIL b2b_regrant actual sel=%0d en=%0b gnt=%02h required 2/1/04",
                     bus.select, bus.EN, bus.gnt);
        end
        bus.req = 8'h00;
        step();
        step();
    endtask

`ifdef BUS_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        bus.req = 8'h04;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({bus.select, bus.EN, bus.timeout} !== {3'd2, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL to_hold%0d actual sel=%0d en=%0b to=%0b required 2/1/0",
                         i, bus.select, bus.EN, bus.timeout);
            end
        end
        step();
        checks++;
        if ({bus.EN, bus.gnt, bus.timeout} !== {1'b0, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL to_revoke actual en=%0b gnt=%02h to=%0b required 0/00/1",
                     bus.EN, bus.gnt, bus.timeout);
        end
        step();
        checks++;
        if ({bus.select, bus.EN, bus.gnt, bus.timeout} !== {3'd2, 1'b1, 8'h04, 1'b0}) begin
            failures++;
            $display("FAIL to_regrant actual sel=%0d en=%0b gnt=%02h to=%0b required 2/1/04/0",
                     bus.select, bus.EN, bus.gnt, bus.timeout);
        end
        bus.req = 8'h00;
        step();
        step();
    endtask
`else
    task automatic test_hold_forever();
        int bad_en;
        int bad_to;
        do_reset();
        bus.req = 8'h04;
        bad_en  = 0;
        bad_to  = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.EN !== 1'b1) bad_en++;
            if (bus.timeout !== 1'b0) bad_to++;
        end
        checks++;
        if (bad_en != 0) begin
            failures++;
            $display("FAIL hold_en actual cycles_low=%0d required 0", bad_en);
        end
        checks++;
        if (bad_to != 0) begin
            failures++;
            $display("FAIL hold_timeout actual cycles_high=%0d required 0", bad_to);
        end
        checks++;
        if ({bus.select, bus.gnt} !== {3'd2, 8'h04}) begin
            failures++;
            $display("FAIL hold_owner actual sel=%0d gnt=%02h required 2/04", bus.select, bus.gnt);
        end
        bus.req = 8'h00;
        step();
        step();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.req  = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_no_preempt();
        test_reset_mid_grant();
        test_back_to_back();
`ifdef BUS_ARBITER_TIMEOUT_EN
        test_timeout();
`else
        test_hold_forever();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 3: select width; number of bus sources N = 2**WIDTH.
REQ-002 SHALL have parameter MAX_HOLD, default 16: grant cycle limit used only when timeout is compiled in.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port req, input, N: request vector; bit i high means source i wants to drive the bus.
REQ-006 SHALL have port select, output, WIDTH: index of the bus owner; feeds the bus select input.
REQ-007 SHALL have port EN, output, 1: bus drive enable; feeds the bus EN input.
REQ-008 SHALL have port gnt, output, N: one-hot grant; zero when EN is low.
REQ-009 SHALL have port timeout, output, 1: single-cycle pulse when a grant is forcibly revoked.

Function
REQ-010 SHALL implement the states IDLE, GRANT and TURN (turnaround); all outputs SHALL be registered.
REQ-011 In IDLE or TURN with any req bit high, SHALL enter GRANT next cycle with select = winner, EN=1, gnt = one-hot(winner).
REQ-012 Winner SHALL be the first requesting index scanning last+1, last+2, ... modulo N, where last is the previous owner; wrap from N-1 to 0.
REQ-013 In IDLE or TURN with req all zero, SHALL go to or stay in IDLE with EN=0 and gnt=0.
REQ-014 Grant latency SHALL be exactly 1 cycle from req sampled high in IDLE to EN high.
REQ-015 In GRANT, SHALL hold select, EN and gnt unchanged while req[select] stays high; requests from other sources SHALL NOT pre-empt the owner.
REQ-016 In GRANT, when req[select] is sampled low, SHALL enter TURN next cycle with EN=0, gnt=0, select held and last updated to select.
REQ-017 TURN SHALL last exactly one cycle, so that EN is low for at least one cycle between any two owners and two sources never drive the bus together.
REQ-018 Back-to-back ownership of the same source SHALL still pass through TURN.
REQ-019 Changes on req bits other than req[select] during GRANT or TURN SHALL have no effect until the next arbitration point.
REQ-020 timeout SHALL be 0 in all cycles except as defined in REQ-024.

Reset
REQ-021 While rst_n is low, SHALL force state IDLE, select=0, EN=0, gnt=0, timeout=0, last=N-1, and hold counter=0, independent of clk.
REQ-022 Reset asserted mid-GRANT SHALL drop EN within the same cycle (asynchronously). After release, the first arbitration SHALL favour source 0.

Configuration
REQ-023 Macro BUS_ARBITER_TIMEOUT_EN SHALL control the timeout feature.
REQ-024 With the macro defined: a hold counter SHALL count GRANT cycles. When the owner has held EN for MAX_HOLD cycles, the next state SHALL be TURN regardless of req, last SHALL be set to the owner, and timeout SHALL be high for exactly that one TURN cycle.
REQ-025 Without the macro: SHALL contain no counter, timeout SHALL be tied to 0, and a grant SHALL be held indefinitely.

Structure
REQ-026 The state encodings (IDLE=2'b00, GRANT=2'b01, TURN=2'b10) SHALL live in a shared package/header for reuse by the control unit.
REQ-027 The round-robin priority search SHALL be a combinational sub-module rr_pick (inputs req and last; outputs winner index and a valid flag).

Verification
REQ-028 Reset then req=8'b0000_0001 -> one cycle later select=0, EN=1, gnt=8'h01. Drop req -> next cycle EN=0 (TURN), following cycle IDLE.
REQ-029 req=8'hFF held from reset -> owners 0,1,2,...,7,0 in order, each GRANT lasting until its bit drops, and EN low for exactly 1 cycle between owners.
REQ-030 Owner 3 in GRANT while req[5] rises -> no change to select/gnt until req[3] drops, then TURN, then select=5.
REQ-031 rst_n pulled low mid-GRANT (owner 6) -> EN=0 and gnt=0 immediately. After release with req=8'h41 -> select=0 wins.
REQ-032 BUS_ARBITER_TIMEOUT_EN defined, MAX_HOLD=4, req[2] held high -> EN high for 4 cycles, then TURN with timeout=1 for 1 cycle, then source 2 is re-granted if it is the only requester.
REQ-033 Macro undefined, req[2] held 100 cycles -> EN high for all 100 cycles and timeout stays 0.
